// File: rtl/gb_cpu_common_pkg.sv
// Shared constants and types for the gameboy CPU core and its bus-side
// helpers, including the OAM DMA controller.
package gb_cpu_common_pkg;

  typedef enum logic [1:0] {
    DMA_IDLE  = 2'd0,
    DMA_START = 2'd1,
    DMA_XFER  = 2'd2
  } dma_state_t;

  localparam logic [15:0] DMA_REG_ADDR     = 16'hFF46;
  localparam logic [7:0]  OAM_DMA_LEN      = 8'd160;
  localparam logic [15:0] HI_REGION_BASE   = 16'hFF00;
  localparam logic [7:0]  DMA_BLOCKED_READ = 8'hFF;

endpackage

// File: rtl/gb_oam_dma.sv
// OAM DMA controller and CPU bus arbiter. A CPU write to FF46 copies 160
// bytes from {src, 8'h00} into OAM, one byte per M-cycle, while the CPU is
// confined to the FF00-FFFF region. The OAM write trails each read by one
// cycle so the external read data can be registered first.
// Optional feature macro: GB_OAM_DMA_START_DELAY_EN inserts a one-cycle
// START state between the FF46 write and the first source read.
module gb_oam_dma
  import gb_cpu_common_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr_i,
  input  logic [7:0]  cpu_data_i,
  input  logic        cpu_drive_data_bus_i,
  output logic [7:0]  cpu_data_o,
  output logic [15:0] ext_addr_o,
  output logic [7:0]  ext_data_o,
  output logic        ext_wren_o,
  input  logic [7:0]  ext_data_i,
  output logic [7:0]  hi_addr_o,
  output logic [7:0]  hi_data_o,
  output logic        hi_wren_o,
  input  logic [7:0]  hi_data_i,
  output logic [7:0]  oam_addr_o,
  output logic [7:0]  oam_data_o,
  output logic        oam_wren_o,
  output logic        busy_o
);

  dma_state_t state_q, state_d;
  logic [7:0] src_q, src_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] byte_q, byte_d;
  logic [7:0] wr_idx_q, wr_idx_d;
  logic       wr_pending_q, wr_pending_d;

  logic hi_region;
  logic dma_reg_hit;
  logic trigger;
  logic busy;

  assign hi_region   = (cpu_addr_i >= HI_REGION_BASE);
  assign dma_reg_hit = (cpu_addr_i == DMA_REG_ADDR);
  assign trigger     = dma_reg_hit && cpu_drive_data_bus_i;
  assign busy        = (state_q != DMA_IDLE) || wr_pending_q;
  assign busy_o      = busy;

  // State register; reset drops any pending OAM write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= DMA_IDLE;
      src_q        <= 8'h00;
      idx_q        <= 8'h00;
      byte_q       <= 8'h00;
      wr_idx_q     <= 8'h00;
      wr_pending_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      idx_q        <= idx_d;
      byte_q       <= byte_d;
      wr_idx_q     <= wr_idx_d;
      wr_pending_q <= wr_pending_d;
    end
  end

  // Sequencing: a read in XFER always completes, then a trigger may restart.
  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    idx_d        = idx_q;
    byte_d       = byte_q;
    wr_idx_d     = wr_idx_q;
    wr_pending_d = 1'b0;
    case (state_q)
      DMA_START: state_d = DMA_XFER;
      DMA_XFER: begin
        byte_d       = ext_data_i;
        wr_idx_d     = idx_q;
        wr_pending_d = 1'b1;
        if (idx_q == OAM_DMA_LEN - 8'd1) begin
          state_d = DMA_IDLE;
        end else begin
          idx_d = idx_q + 8'd1;
        end
      end
      default: state_d = state_q;
    endcase
    if (trigger) begin
      src_d = cpu_data_i;
      idx_d = 8'h00;
`ifdef GB_OAM_DMA_START_DELAY_EN
      state_d = DMA_START;
`else
      state_d = DMA_XFER;
`endif
    end
  end

  // Bus routing: DMA owns the external bus while busy, CPU keeps FFxx.
  always_comb begin
    ext_addr_o = 16'h0000;
    ext_data_o = 8'h00;
    ext_wren_o = 1'b0;
    hi_addr_o  = cpu_addr_i[7:0];
    hi_data_o  = cpu_data_i;
    hi_wren_o  = hi_region && cpu_drive_data_bus_i && !dma_reg_hit;
    oam_wren_o = wr_pending_q;
    oam_addr_o = wr_pending_q ? wr_idx_q : 8'h00;
    oam_data_o = wr_pending_q ? byte_q : 8'h00;
    if (state_q == DMA_XFER) begin
      ext_addr_o = {src_q, idx_q};
    end else if (!busy && !hi_region) begin
      ext_addr_o = cpu_addr_i;
      ext_data_o = cpu_data_i;
      ext_wren_o = cpu_drive_data_bus_i;
    end
    if (hi_region) begin
      cpu_data_o = dma_reg_hit ? src_q : hi_data_i;
    end else begin
      cpu_data_o = busy ? DMA_BLOCKED_READ : ext_data_i;
    end
  end

endmodule

// File: tb/tb_gb_oam_dma.sv
// Self-checking bench for gb_oam_dma. A schedule model, indexed by cycle
// number, records when the DMA should be busy and which OAM write should
// appear, derived from the trigger/restart/reset timing rules.
module tb_gb_oam_dma;

`ifdef GB_OAM_DMA_START_DELAY_EN
  localparam int L = 1;
`else
  localparam int L = 0;
`endif
  localparam int MAXC = 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpuAddr;
  logic [7:0]  cpuWrData;
  logic        cpuDrive;
  logic [7:0]  cpuRdData;
  logic [15:0] extAddr;
  logic [7:0]  extWrData;
  logic        extWren;
  logic [7:0]  extRdData;
  logic [7:0]  hiAddr;
  logic [7:0]  hiWrData;
  logic        hiWren;
  logic [7:0]  hiRdData;
  logic [7:0]  oamAddr;
  logic [7:0]  oamData;
  logic        oamWren;
  logic        busy;

  logic [7:0] extMem [65536];
  logic [7:0] hiMem [256];
  logic [7:0] oamShadow [256];

  bit         expBusy [MAXC];
  bit         expWr [MAXC];
  logic [7:0] expWrIdx [MAXC];
  logic [7:0] expWrData [MAXC];

  int cyc = 0;
  int testCount = 0;
  int failCount = 0;
  int wrCount = 0;

  assign extRdData = extMem[extAddr];
  assign hiRdData  = hiMem[hiAddr];

  always #5 clk = ~clk;

  gb_oam_dma dut (
    .clk                  (clk),
    .reset                (reset),
    .cpu_addr_i           (cpuAddr),
    .cpu_data_i           (cpuWrData),
    .cpu_drive_data_bus_i (cpuDrive),
    .cpu_data_o           (cpuRdData),
    .ext_addr_o           (extAddr),
    .ext_data_o           (extWrData),
    .ext_wren_o           (extWren),
    .ext_data_i           (extRdData),
    .hi_addr_o            (hiAddr),
    .hi_data_o            (hiWrData),
    .hi_wren_o            (hiWren),
    .hi_data_i            (hiRdData),
    .oam_addr_o           (oamAddr),
    .oam_data_o           (oamData),
    .oam_wren_o           (oamWren),
    .busy_o               (busy)
  );

  // Captures every OAM write into a shadow copy of OAM.
  always @(negedge clk) begin
    if (oamWren) begin
      oamShadow[oamAddr] = oamData;
      wrCount = wrCount + 1;
    end
  end

  // A trigger in cycle t keeps the write from a read in t, then reads idx j
  // in t+1+L+j and writes it one cycle later.
  function automatic void scheduleDma(input int t, input logic [7:0] s);
    for (int c = t + 2; c < MAXC; c++) begin
      expBusy[c] = 1'b0;
      expWr[c]   = 1'b0;
    end
    for (int c = t + 1; c <= t + 161 + L; c++) expBusy[c] = 1'b1;
    for (int j = 0; j < 160; j++) begin
      expWr[t + 2 + L + j]     = 1'b1;
      expWrIdx[t + 2 + L + j]  = 8'(j);
      expWrData[t + 2 + L + j] = extMem[{s, 8'(j)}];
    end
  endfunction

  function automatic void resetAt(input int x);
    for (int c = x + 1; c < MAXC; c++) begin
      expBusy[c] = 1'b0;
      expWr[c]   = 1'b0;
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] obs,
                             input logic [15:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic [7:0] d,
                               input logic w);
    cpuAddr   = a;
    cpuWrData = d;
    cpuDrive  = w;
  endtask

  task automatic endCycle();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic checkCycle();
    checkOutput("busy", {15'd0, busy}, {15'd0, expBusy[cyc]});
    checkOutput("oam_wren", {15'd0, oamWren}, {15'd0, expWr[cyc]});
    if (expWr[cyc]) begin
      checkOutput("oam_addr", {8'd0, oamAddr}, {8'd0, expWrIdx[cyc]});
      checkOutput("oam_data", {8'd0, oamData}, {8'd0, expWrData[cyc]});
    end
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(16'hFF85, 8'h00, 1'b0);
      #1;
      checkCycle();
      endCycle();
    end
  endtask

  task automatic triggerDma(input logic [7:0] s);
    applyStimulus(16'hFF46, s, 1'b1);
    #1;
    checkCycle();
    checkOutput("ff46_hi_wren", {15'd0, hiWren}, 16'd0);
    scheduleDma(cyc, s);
    endCycle();
  endtask

  task automatic checkShadow(input string tag, input logic [7:0] s);
    for (int i = 0; i < 160; i++)
      checkOutput(tag, {8'd0, oamShadow[i]}, {8'd0, extMem[{s, 8'(i)}]});
  endtask

  task automatic checkSrcReg(input string tag, input logic [7:0] s);
    applyStimulus(16'hFF46, 8'h00, 1'b0);
    #1;
    checkOutput(tag, {8'd0, cpuRdData}, {8'd0, s});
    endCycle();
  endtask

  // Directed sequence of scenarios with randomized memory contents.
  initial begin
    logic [7:0]  srcA, srcB, hiVal;
    logic [15:0] rdAddr;
    int          w0;
    for (int i = 0; i < 65536; i++) extMem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) hiMem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) oamShadow[i] = 8'h00;

    reset = 1'b1;
    applyStimulus(16'hFF85, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 1;

    // Reset state.
    #1;
    checkOutput("rst_busy", {15'd0, busy}, 16'd0);
    checkOutput("rst_oam_wren", {15'd0, oamWren}, 16'd0);
    checkOutput("rst_ext_wren", {15'd0, extWren}, 16'd0);
    endCycle();
    checkSrcReg("rst_src", 8'h00);

    // Idle passthrough write and read.
    applyStimulus(16'hC000, 8'h5A, 1'b1);
    #1;
    checkOutput("idle_ext_addr", extAddr, 16'hC000);
    checkOutput("idle_ext_data", {8'd0, extWrData}, 16'h005A);
    checkOutput("idle_ext_wren", {15'd0, extWren}, 16'd1);
    checkOutput("idle_oam_wren", {15'd0, oamWren}, 16'd0);
    endCycle();
    rdAddr = 16'($urandom_range(0, 16'hFEFF));
    applyStimulus(rdAddr, 8'h00, 1'b0);
    #1;
    checkOutput("idle_ext_read", {8'd0, cpuRdData}, {8'd0, extMem[rdAddr]});
    endCycle();

    // Full transfer from C1 with CPU accesses while busy.
    w0 = wrCount;
    triggerDma(8'hC1);
    hiVal = 8'($urandom);
    for (int k = 1; k <= 170; k++) begin
      case (k)
        20:      applyStimulus(16'h8000, 8'h00, 1'b0);
        21:      applyStimulus(16'hC000, 8'h77, 1'b1);
        22:      applyStimulus(16'hFF85, 8'h00, 1'b0);
        23:      applyStimulus(16'hFF85, hiVal, 1'b1);
        default: applyStimulus(16'hFF80, 8'h00, 1'b0);
      endcase
      #1;
      checkCycle();
      if (k == 20) checkOutput("busy_blocked_read", {8'd0, cpuRdData}, 16'h00FF);
      if (k == 21) checkOutput("busy_dropped_write", {15'd0, extWren}, 16'd0);
      if (k == 22) checkOutput("busy_hi_read", {8'd0, cpuRdData}, {8'd0, hiMem[8'h85]});
      if (k == 23) begin
        checkOutput("busy_hi_wren", {15'd0, hiWren}, 16'd1);
        checkOutput("busy_hi_addr", {8'd0, hiAddr}, 16'h0085);
        checkOutput("busy_hi_data", {8'd0, hiWrData}, {8'd0, hiVal});
      end
      endCycle();
    end
    checkOutput("c1_write_count", 16'(wrCount - w0), 16'd160);
    checkShadow("c1_oam", 8'hC1);
    checkSrcReg("c1_src_readback", 8'hC1);

    // Restart at idx 50 with a new random source.
    srcA = 8'($urandom);
    srcB = 8'($urandom);
    w0 = wrCount;
    triggerDma(srcA);
    runCycles(50 + L);
    triggerDma(srcB);
    runCycles(170);
    checkOutput("restart_write_count", 16'(wrCount - w0), 16'd211);
    checkShadow("restart_oam", srcB);
    checkSrcReg("restart_src", srcB);

    // Restart in the same cycle as the final read.
    srcA = 8'($urandom);
    srcB = 8'($urandom);
    w0 = wrCount;
    triggerDma(srcA);
    runCycles(159 + L);
    triggerDma(srcB);
    runCycles(170);
    checkOutput("lastread_write_count", 16'(wrCount - w0), 16'd320);
    checkShadow("lastread_oam", srcB);

    // Reset asserted while idx 80 is being read.
    srcA = 8'($urandom);
    w0 = wrCount;
    triggerDma(srcA);
    runCycles(80 + L);
    applyStimulus(16'hFF85, 8'h00, 1'b0);
    reset = 1'b1;
    #1;
    checkCycle();
    resetAt(cyc);
    endCycle();
    reset = 1'b0;
    runCycles(5);
    checkOutput("reset_write_count", 16'(wrCount - w0), 16'd80);
    checkSrcReg("reset_src", 8'h00);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/gb_oam_dma.md
# gb_oam_dma

OAM DMA controller and bus arbiter between the gameboy CPU core (`gb_cpu`) and the system memory map. A CPU write to FF46 starts a 160-byte copy from `{src, 8'h00}` to OAM, one byte per M-cycle. During the copy the block owns the external bus and confines the CPU to the FF00–FFFF high region. It also owns the FF46 register itself.

## Interface
Parameters: none (constants in package).
- `clk` in 1: machine (M) clock
- `reset` in 1: synchronous, active-high
- `cpu_addr_i` in 16: CPU `addr_o`
- `cpu_data_i` in 8: CPU `data_o`
- `cpu_drive_data_bus_i` in 1: CPU write strobe (0 = read)
- `cpu_data_o` out 8: to CPU `data_i`
- `ext_addr_o` out 16: external bus address, covers 0000–FEFF
- `ext_data_o` out 8: external write data
- `ext_wren_o` out 1: external write enable
- `ext_data_i` in 8: external read data, combinational from `ext_addr_o`
- `hi_addr_o` out 8: low byte of FFxx
- `hi_data_o` out 8: high-region write data
- `hi_wren_o` out 1: high-region write enable
- `hi_data_i` in 8: high-region read data
- `oam_addr_o` out 8: OAM index
- `oam_data_o` out 8: OAM write data
- `oam_wren_o` out 1: OAM write enable
- `busy_o` out 1: DMA in progress

## Operation
- States: IDLE, START (only when the macro is defined), XFER. Internal state:
  - 8-bit `src_q`
  - 8-bit `idx_q`
  - `wr_pending_q`
  - 8-bit `byte_q`
- Trigger: `cpu_addr_i==16'hFF46 && cpu_drive_data_bus_i`.
  - `src_q<=cpu_data_i`, `idx_q<=0`, go to START or XFER.
  - Valid from any state, including mid-transfer (restart).
- XFER cycle:
  - `ext_addr_o={src_q,idx_q}`, `ext_wren_o=0`.
  - `byte_q<=ext_data_i`, `wr_pending_q<=1`.
  - `idx_q==159` → IDLE; otherwise `idx_q++`.
- OAM write is pipelined one cycle behind the read: when `wr_pending_q`, `oam_wren_o=1`, `oam_addr_o=idx` of the previous read, `oam_data_o=byte_q`. `wr_pending_q` clears when no read occurs.
- Source address is used unmodified; no range checks.
- CPU routing with `cpu_addr_i>=FF00`:
  - Always passes to the hi port: `hi_addr_o=cpu_addr_i[7:0]`, `hi_wren_o=cpu_drive_data_bus_i`.
  - FF46 is not forwarded; `hi_wren_o=0` for it.
  - Reads of FF46 return `src_q`; other reads return `hi_data_i`.
- CPU routing with `cpu_addr_i<FF00`:
  - `busy_o=0`: the CPU drives the ext port and `cpu_data_o=ext_data_i`.
  - `busy_o=1`: CPU writes are dropped and reads return 8'hFF.
- `busy_o = (state!=IDLE) | wr_pending_q`.
- Reset: IDLE, `src_q=0`, `idx_q=0`, `wr_pending_q=0`. All outputs 0 except the combinational CPU passthrough.

## Timing
- FF46 write in cycle T; the register updates at the end of T.
- With the macro: START in T+1; reads in T+2..T+161; OAM writes in T+3..T+162; `busy_o` high T+1..T+162.
- Without the macro: reads in T+1..T+160; OAM writes in T+2..T+161; `busy_o` high T+1..T+161.
- Restart in cycle R during XFER:
  - The read in R still completes, and its OAM write happens in R+1.
  - The new sequence starts per the rules above; idx 0 is read in R+1 without the macro, R+2 with it.
- FF46 write and the last read in the same cycle: the restart wins, and the final pending write still lands.
- Reset during a transfer: the next cycle is IDLE and no pending OAM write is issued.
- All decode and muxing is combinational; the only latency is the registered state.

## Configuration
- `GB_OAM_DMA_START_DELAY_EN` defined: one-M-cycle START state between trigger and first read (hardware-accurate).
- Undefined: START is omitted; XFER is entered directly.

## Structure
- `gb_cpu_common_pkg` gains:
  - `dma_state_t` enum
  - `DMA_REG_ADDR=16'hFF46`
  - `OAM_DMA_LEN=8'd160`
  - `HI_REGION_BASE=16'hFF00`
  - `DMA_BLOCKED_READ=8'hFF`
- Single module; no sub-module is warranted. Sequencing and routing fit in about 150 lines.

## Test plan
- Write 8'hC1 to FF46 (macro off): OAM writes idx 0..159 with data from C100..C19F, idx 0 at T+2; `busy_o` falls after T+161; FF46 reads back 8'hC1.
- Same with the macro on: first ext read at T+2, first OAM write at T+3, 160 writes total.
- During busy, CPU read of 8000 returns 8'hFF and CPU write to C000 yields `ext_wren_o=0`; read of FF85 returns `hi_data_i`; write to FF85 yields `hi_wren_o=1`.
- Restart to 8'hD0 at idx 50: byte from C132 is written at idx 50, then idx 0 restarts with D000; exactly 160 writes from the D0 source.
- Assert `reset` at idx 80: `oam_wren_o=0` and `busy_o=0` the next cycle; `src_q` reads 0.
- Idle passthrough: write 8'h5A to C000 yields `ext_addr_o=C000`, `ext_data_o=5A`, `ext_wren_o=1`; `oam_wren_o` stays 0.
